approx_laplace_sub_seq: RTL

Sequential approximate Laplacian core: computes N_TERMS*center - sum(neighbors), one subtraction per cycle.
- Datapath is a ripple-borrow subtractor whose top APPROX_BITS cells are approximate. It is the subtract-direction counterpart of the approximate ripple-carry adders.
- Sits between the window buffer and the thresholding stage of the filter pipeline.
- valid/ready handshake on both input and output.

---
 rtl/approx_pkg.sv | 23 ++
 rtl/approx_laplace_sub_seq_if.sv | 44 ++++
 rtl/approx_rb_subtractor.sv | 34 +++
 rtl/approx_laplace_sub_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/approx_pkg.sv
// approx_pkg: shared types and width-derivation helpers for the approximate
// Laplacian subtract core (approx_laplace_sub_seq).
package approx_pkg;

   // Control states of the sequential subtract core.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Number of bits needed to express a multiply by n_terms as a shift.
   function automatic int calc_lg(input int n_terms);
      return $clog2(n_terms);
   endfunction

   // Accumulator/result width: pixel width, plus headroom for the
   // N_TERMS*center term, plus one sign bit.
   function automatic int calc_aw(input int width, input int n_terms);
      return width + calc_lg(n_terms) + 1;
   endfunction

endpackage

// File: rtl/approx_laplace_sub_seq_if.sv
// approx_laplace_sub_seq_if: input-window and result handshake bundle.
// The master side (window buffer / thresholding stage) drives the window and
// out_ready; the slave side (the core) drives in_ready and the result.
interface approx_laplace_sub_seq_if
   import approx_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int N_TERMS = 4
) ();

   localparam int AW = calc_aw(WIDTH, N_TERMS);

   logic                       in_valid;
   logic                       in_ready;
   logic [WIDTH-1:0]           center;
   logic [N_TERMS*WIDTH-1:0]   neighbors;
   logic                       out_valid;
   logic                       out_ready;
   logic [AW-1:0]              result;
   logic [AW-1:0]              err;

   modport master (
      output in_valid,
      output center,
      output neighbors,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  result,
      input  err
   );

   modport slave (
      input  in_valid,
      input  center,
      input  neighbors,
      input  out_ready,
      output in_ready,
      output out_valid,
      output result,
      output err
   );

endinterface

// File: rtl/approx_rb_subtractor.sv
// approx_rb_subtractor: combinational ripple-borrow subtractor d = a - b.
// The low W-APPROX_BITS cells are full subtractors; the top APPROX_BITS
// cells ignore their incoming borrow (d = a ^ b). The final borrow-out is
// dropped, so the difference wraps mod 2^W. APPROX_BITS = 0 gives an exact
// subtractor.
module approx_rb_subtractor #(
   parameter int W           = 11,
   parameter int APPROX_BITS = 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] d
);

   // Running borrow between cells; only the exact cells consume it.
   logic borrow_s;

   // Ripple the borrow LSB-first through the cell chain.
   always_comb begin
      d        = {W{1'b0}};
      borrow_s = 1'b0;
      for (int k = 0; k < W; k++) begin
         if (k < W - APPROX_BITS) begin
            d[k]     = a[k] ^ b[k] ^ borrow_s;
            borrow_s = (~a[k] & b[k]) | (~(a[k] ^ b[k]) & borrow_s);
         end else begin
            // Approximate cell: incoming borrow is discarded.
            d[k]     = a[k] ^ b[k];
            borrow_s = ~a[k] & b[k];
         end
      end
   end

endmodule

// File: rtl/approx_laplace_sub_seq.sv
// approx_laplace_sub_seq: sequential approximate Laplacian core.
// Computes N_TERMS*center - sum(neighbors) with one ripple-borrow subtraction
// per cycle; the top APPROX_BITS subtractor cells are approximate.
// Optional feature macro: APPROX_ERR_MON_EN -- when defined, an exact
// accumulator runs in lockstep and err reports exact minus approximate
// (mod 2^AW); when undefined, err is tied to zero.
module approx_laplace_sub_seq
   import approx_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int N_TERMS     = 4,
   parameter int APPROX_BITS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   approx_laplace_sub_seq_if.slave  bus
);

   localparam int LG  = calc_lg(N_TERMS);
   localparam int AW  = calc_aw(WIDTH, N_TERMS);
   localparam int NBW = N_TERMS * WIDTH;

   state_e           state_q, state_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [NBW-1:0]   terms_q, terms_d;
   logic [LG-1:0]    idx_q, idx_d;

   logic [AW-1:0]    center_ext_s;
   logic [AW-1:0]    seed_s;
   logic [AW-1:0]    term_s;
   logic [AW-1:0]    approx_diff_s;
   logic             accept_s;

   // N_TERMS*center is a left shift of the zero-extended center pixel.
   assign center_ext_s = {{(LG + 1){1'b0}}, bus.center};
   assign seed_s       = center_ext_s << LG;
   assign accept_s     = (state_q == IDLE) && bus.in_valid;

   // Neighbor currently being subtracted, zero-extended to the accumulator.
   assign term_s = {{(AW - WIDTH){1'b0}}, terms_q[idx_q*WIDTH +: WIDTH]};

   approx_rb_subtractor #(
      .W           (AW),
      .APPROX_BITS (APPROX_BITS)
   ) u_approx_sub (
      .a (acc_q),
      .b (term_s),
      .d (approx_diff_s)
   );

   // Next-state and datapath-update decode for the IDLE/SUB/DONE sequence.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      terms_d = terms_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               acc_d   = seed_s;
               terms_d = bus.neighbors;
               idx_d   = {LG{1'b0}};
               state_d = SUB;
            end else begin
               state_d = IDLE;
            end
         end
         SUB: begin
            acc_d = approx_diff_s;
            idx_d = idx_q + 1'b1;
            if (idx_q == LG'(N_TERMS - 1)) begin
               state_d = DONE;
            end else begin
               state_d = SUB;
            end
         end
         DONE: begin
            // Result is held until the downstream stage takes it.
            if (bus.out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, accumulator, term latch and index registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= {AW{1'b0}};
         terms_q <= {NBW{1'b0}};
         idx_q   <= {LG{1'b0}};
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         terms_q <= terms_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = acc_q;

`ifdef APPROX_ERR_MON_EN
   logic [AW-1:0] exact_q, exact_d;
   logic [AW-1:0] exact_diff_s;
   logic [AW-1:0] err_q, err_d;

   approx_rb_subtractor #(
      .W           (AW),
      .APPROX_BITS (0)
   ) u_exact_sub (
      .a (exact_q),
      .b (term_s),
      .d (exact_diff_s)
   );

   // Exact accumulator follows the same seed/subtract schedule as acc.
   always_comb begin
      exact_d = exact_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               exact_d = seed_s;
            end else begin
               exact_d = exact_q;
            end
         end
         SUB: begin
            exact_d = exact_diff_s;
         end
         DONE: begin
            exact_d = exact_q;
         end
         default: begin
            exact_d = exact_q;
         end
      endcase
      err_d = exact_d - acc_d;
   end

   // Exact accumulator and registered error output.
   always_ff @(posedge clk) begin
      if (rst) begin
         exact_q <= {AW{1'b0}};
         err_q   <= {AW{1'b0}};
      end else begin
         exact_q <= exact_d;
         err_q   <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = {AW{1'b0}};
`endif

endmodule
